ysyx_22040632_divu: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the RV64M extension ALU.
//  It is the inverse of the Booth multiplier datapath and executes DIV/DIVU/REM/REMU and the W forms.
//  It accepts one operation per valid/ready handshake, iterates one quotient bit per cycle, and holds the result until the consumer takes it.
//  It sits beside the multiplier in alu_ext and is driven by EXU.

---
 rtl/ysyx_22040632_div_pkg.sv | 28 ++
 rtl/ysyx_22040632_div_step.sv | 23 ++
 rtl/ysyx_22040632_divu.sv | 147 ++++++++++++++
 tb/tb_ysyx_22040632_divu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_div_pkg.sv
// Shared types and constants for the RV64M restoring divider.
package ysyx_22040632_div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Most negative values; the word form is already sign-extended to XLEN.
    localparam logic [XLEN-1:0] DWORD_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] WORD_MIN  = {{(XLEN-32){1'b1}}, 1'b1, 31'b0};

    typedef struct packed {
        logic [XLEN-1:0] dividend;
        logic [XLEN-1:0] divisor;
        logic            div_signed;
        logic            div_word;
    } div_req_t;

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sext);
        return sext ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22040632_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module ysyx_22040632_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so |diff| < 2^WIDTH and diff[WIDTH] is the borrow.
    always_comb begin
        shifted  = {rem, next_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/ysyx_22040632_divu.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
module ysyx_22040632_divu
    import ysyx_22040632_div_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             div_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_reg, state_next;
    logic [CW-1:0]    counter_reg;
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             word_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             out_valid_reg;

    div_req_t         req;
    logic [WIDTH-1:0] op_a, op_b, abs_a, abs_b, min_val;
    logic             a_neg, b_neg, div_zero, overflow, accept;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_fix, r_fix, q_final, r_final;

    // Operand preparation, evaluated only in the accept cycle.
    always_comb begin
        req      = '{dividend: dividend, divisor: divisor,
                     div_signed: div_signed, div_word: div_word};
        op_a     = req.div_word ? word_ext(req.dividend, req.div_signed) : req.dividend;
        op_b     = req.div_word ? word_ext(req.divisor, req.div_signed) : req.divisor;
        a_neg    = req.div_signed & op_a[WIDTH-1];
        b_neg    = req.div_signed & op_b[WIDTH-1];
        abs_a    = a_neg ? -op_a : op_a;
        abs_b    = b_neg ? -op_b : op_b;
        min_val  = req.div_word ? WORD_MIN : DWORD_MIN;
        div_zero = (op_b == '0);
        overflow = req.div_signed && (op_a == min_val) && (op_b == '1);
        accept   = div_valid && (state_reg == IDLE) && !flush;
    end

    ysyx_22040632_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .divisor  (divisor_reg),
        .next_bit (dq_reg[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Sign fix-up first, then the W-form extension of the 32-bit result.
    always_comb begin
        q_fix   = q_neg_reg ? -dq_reg : dq_reg;
        r_fix   = r_neg_reg ? -rem_reg : rem_reg;
        q_final = word_reg ? {{(WIDTH-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
        r_final = word_reg ? {{(WIDTH-32){r_fix[31]}}, r_fix[31:0]} : r_fix;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (div_zero || overflow) ? DONE : CALC;
            CALC: if (counter_reg == '0) state_next = FIN;
            FIN:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            dq_reg        <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            word_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: if (accept) begin
                        dq_reg      <= abs_a;
                        divisor_reg <= abs_b;
                        rem_reg     <= '0;
                        counter_reg <= CW'(WIDTH - 1);
                        q_neg_reg   <= a_neg ^ b_neg;
                        r_neg_reg   <= a_neg;
                        word_reg    <= div_word;
                        if (div_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= op_a;
                            out_valid_reg <= 1'b1;
                        end else if (overflow) begin
                            quotient_reg  <= min_val;
                            remainder_reg <= '0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    // dq_reg feeds dividend bits out of the top and collects quotient bits at the bottom.
                    CALC: begin
                        dq_reg  <= {dq_reg[WIDTH-2:0], q_bit};
                        rem_reg <= rem_next;
                        if (counter_reg != '0) counter_reg <= counter_reg - 1'b1;
                    end
                    FIN: begin
                        quotient_reg  <= q_final;
                        remainder_reg <= r_final;
                        out_valid_reg <= 1'b1;
                    end
                    DONE: if (out_ready) out_valid_reg <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign div_ready = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_ysyx_22040632_divu.sv
// Directed bench for the restoring divider: arithmetic model, latency, hold, flush and reset.
module tb_ysyx_22040632_divu;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_signed;
    logic        div_word;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q, exp_r;
    bit          exp_pending = 1'b0;

    always #5 clk = ~clk;

    ysyx_22040632_divu #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_signed (div_signed),
        .div_word   (div_word),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // RISC-V M-extension semantics expressed with plain 64-bit arithmetic.
    function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in,
                                  input bit s, input bit w,
                                  output logic [63:0] q, output logic [63:0] r);
        logic [63:0] a, b, mn;
        a = a_in;
        b = b_in;
        if (w) begin
            a = s ? {{32{a_in[31]}}, a_in[31:0]} : {32'h0, a_in[31:0]};
            b = s ? {{32{b_in[31]}}, b_in[31:0]} : {32'h0, b_in[31:0]};
        end
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (s && a == mn && b == '1) begin
            q = mn;
            r = 64'd0;
        end else begin
            if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            if (w) begin
                q = {{32{q[31]}}, q[31:0]};
                r = {{32{r[31]}}, r[31:0]};
            end
        end
    endfunction

    // Whenever a result is presented it must match the model for the accepted request.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (!exp_pending) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_valid=1 expected 0 (q=%h r=%h)", quotient, remainder);
            end else begin
                check64("model_q", quotient, exp_q);
                check64("model_r", remainder, exp_r);
            end
        end
    end

    task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit w, input logic [63:0] lq, input logic [63:0] lr,
                         input int lat, input int hold);
        logic [63:0] mq, mr;
        int t;
        model(a, b, s, w, mq, mr);
        check64({name, "_model_q"}, mq, lq);
        check64({name, "_model_r"}, mr, lr);
        t = 0;
        while (div_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        dividend    = a;
        divisor     = b;
        div_signed  = s;
        div_word    = w;
        div_valid   = 1'b1;
        exp_q       = mq;
        exp_r       = mr;
        exp_pending = 1'b1;
        @(posedge clk); #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = 1'($urandom);
        div_word   = 1'($urandom);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (out_valid !== 1'b1 && t < 200);
        check64({name, "_latency"}, 64'(t), 64'(lat));
        check64({name, "_q"}, quotient, lq);
        check64({name, "_r"}, remainder, lr);
        $display("op %s: a=%h b=%h s=%0d w=%0d -> q=%h r=%h after %0d cycles",
                 name, a, b, s, w, quotient, remainder, t);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check64({name, "_hold_q"}, quotient, lq);
            check64({name, "_hold_r"}, remainder, lr);
            check64({name, "_hold_ready"}, {63'd0, div_ready}, 64'd0);
            check64({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready   = 1'b0;
        exp_pending = 1'b0;
        check64({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check64({name, "_ready_back"}, {63'd0, div_ready}, 64'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check64(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        div_valid  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_signed = 1'b0;
        div_word   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_valid", {63'd0, out_valid}, 64'd0);
        check64("reset_q", quotient, 64'd0);
        check64("reset_r", remainder, 64'd0);
        check64("reset_ready", {63'd0, div_ready}, 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("divu_100_7",   64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 65, 0);
        do_op("div_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        do_op("rem_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0,
              64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 0);
        do_op("divu_by_zero", 64'h1234, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0);
        do_op("div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0,
              64'h8000_0000_0000_0000, 64'd0, 1, 0);
        do_op("divw_ovf",     64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1,
              64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
        do_op("divuw_hold",   64'h0000_0000_FFFF_FFFF, 64'd2, 0, 1,
              64'h0000_0000_7FFF_FFFF, 64'd1, 65, 10);
        do_op("divuw_hi_ign", 64'h0000_0001_0000_0064, 64'd7, 0, 1, 64'd14, 64'd2, 65, 0);
        do_op("remw_m7_2",    64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        do_op("divw_7_m2",    64'd7, 64'h0000_0000_FFFF_FFFE, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 0);
        do_op("divu_max_1",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 0);
        do_op("divu_5_10",    64'd5, 64'd10, 0, 0, 64'd0, 64'd5, 65, 0);
        do_op("div_min_2",    64'h8000_0000_0000_0000, 64'd2, 1, 0,
              64'hC000_0000_0000_0000, 64'd0, 65, 0);

        // Flush in the middle of an iteration.
        dividend = 64'd1000; divisor = 64'd3; div_signed = 1'b0; div_word = 1'b0;
        div_valid = 1'b1; exp_pending = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1; exp_pending = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("op flush_calc: ready=%0d valid=%0d", div_ready, out_valid);
        check64("flush_valid", {63'd0, out_valid}, 64'd0);
        check64("flush_ready", {63'd0, div_ready}, 64'd1);
        expect_quiet("flush_quiet", 70);
        do_op("divu_9_3", 64'd9, 64'd3, 0, 0, 64'd3, 64'd0, 65, 0);

        // Flush together with a request in IDLE: the request must be dropped.
        dividend = 64'd9; divisor = 64'd3; div_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; flush = 1'b0;
        $display("op flush_idle: ready=%0d valid=%0d", div_ready, out_valid);
        check64("flush_idle_ready", {63'd0, div_ready}, 64'd1);
        expect_quiet("flush_idle_quiet", 70);

        // Asynchronous reset while iterating clears the held 9/3 result at once.
        dividend = 64'd50; divisor = 64'd7; div_valid = 1'b1; exp_pending = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_pending = 1'b0;
        $display("op reset_calc: valid=%0d q=%h r=%h ready=%0d", out_valid, quotient, remainder, div_ready);
        check64("rst_calc_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_calc_q", quotient, 64'd0);
        check64("rst_calc_r", remainder, 64'd0);
        check64("rst_calc_ready", {63'd0, div_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op("divu_after_rst", 64'd50, 64'd7, 0, 0, 64'd7, 64'd1, 65, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
